// File: rtl/dmem_lsu.sv
// Load/store unit: turns RV32I byte/half/word requests into byte-enabled word
// accesses on the data SRAM, splitting word-crossing accesses in two.
//
// state   | meaning
// S_IDLE  | accepting requests; SRAM port driven straight from the request
// S_SPLIT | issuing the registered second half of a word-crossing access
module dmem_lsu #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_vld,
    input  logic          req_ld,
    input  logic          req_st,
    input  logic [2:0]    req_f3,
    input  logic [31:0]   req_a,
    input  logic [31:0]   req_wd,
    output logic          req_rdy,
    output logic [AW-1:0] dat_a,
    output logic [3:0]    dat_we,
    output logic [31:0]   dat_wd,
    output logic [3:0]    dat_re,
    input  logic [31:0]   dat_rd,
    output logic          rsp_vld,
    output logic [31:0]   rsp_rd,
    output logic          err
);

    typedef enum logic {S_IDLE, S_SPLIT} state_t;

    state_t        state, state_nxt;
    logic          acc, legal, go, is_split;
    logic [3:0]    size_mask, lo_mask, hi_mask;
    logic [7:0]    lanes;
    logic [63:0]   wd_sh;
    logic [AW-1:0] word_a;

    logic [AW-1:0] sec_a;
    logic [3:0]    sec_mask, fst_mask;
    logic [31:0]   sec_wd;
    logic          sec_ld, sec_st;

    logic          pend_vld, pend_split;
    logic [1:0]    pend_o;
    logic [2:0]    pend_f3;
    logic [3:0]    pend_mask;
    logic [31:0]   merge_q;

    logic [31:0]   live, sh32, ext;
    logic [63:0]   merged, shifted;
    logic          unused_bits;

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    always_comb begin
        size_mask = 4'b0000;
        legal     = 1'b0;
        case (req_f3)
            3'b000:  begin size_mask = 4'b0001; legal = 1'b1;   end
            3'b001:  begin size_mask = 4'b0011; legal = 1'b1;   end
            3'b010:  begin size_mask = 4'b1111; legal = 1'b1;   end
            3'b100:  begin size_mask = 4'b0001; legal = req_ld; end
            3'b101:  begin size_mask = 4'b0011; legal = req_ld; end
            default: begin size_mask = 4'b0000; legal = 1'b0;   end
        endcase
    end

    // Lane mask over two consecutive words; the upper nibble is the spill-over.
    assign lanes    = {4'b0000, size_mask} << req_a[1:0];
    assign lo_mask  = lanes[3:0];
    assign hi_mask  = lanes[7:4];
    assign is_split = |hi_mask;
    assign wd_sh    = {32'h0, req_wd} << {req_a[1:0], 3'b000};
    assign word_a   = {req_a[AW-1:2], 2'b00};

    assign req_rdy = ~rst & (state == S_IDLE);
    assign acc     = req_rdy & req_vld & (req_ld ^ req_st);
    assign go      = acc & legal;
    assign err     = acc & ~legal;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go && is_split) state_nxt = S_SPLIT;
            S_SPLIT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dat_a  = '0;
        dat_we = 4'b0000;
        dat_re = 4'b0000;
        dat_wd = 32'h0;
        if (!rst) begin
            if (state == S_SPLIT) begin
                dat_a  = sec_a;
                dat_wd = sec_wd;
                dat_we = sec_st ? sec_mask : 4'b0000;
                dat_re = sec_ld ? sec_mask : 4'b0000;
            end else if (go) begin
                dat_a  = word_a;
                dat_wd = wd_sh[31:0];
                dat_we = req_st ? lo_mask : 4'b0000;
                dat_re = req_ld ? lo_mask : 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_a      <= '0;
            sec_mask   <= 4'b0000;
            fst_mask   <= 4'b0000;
            sec_wd     <= 32'h0;
            sec_ld     <= 1'b0;
            sec_st     <= 1'b0;
            pend_vld   <= 1'b0;
            pend_split <= 1'b0;
            pend_o     <= 2'b00;
            pend_f3    <= 3'b000;
            pend_mask  <= 4'b0000;
            merge_q    <= 32'h0;
        end else begin
            if (go && is_split) begin
                sec_a    <= word_a + AW'(4);
                sec_mask <= hi_mask;
                fst_mask <= lo_mask;
                sec_wd   <= wd_sh[63:32];
                sec_ld   <= req_ld;
                sec_st   <= req_st;
            end
            if (go) begin
                pend_o  <= req_a[1:0];
                pend_f3 <= req_f3;
            end
            if (state == S_SPLIT) begin
                pend_vld   <= sec_ld;
                pend_split <= 1'b1;
                pend_mask  <= sec_mask;
                merge_q    <= dat_rd & lane_bits(fst_mask);
            end else begin
                pend_vld   <= go & req_ld & ~is_split;
                pend_split <= 1'b0;
                pend_mask  <= lo_mask;
            end
        end
    end

    // Only enabled lanes reach the result; the rest of dat_rd is undefined.
    assign live    = dat_rd & lane_bits(pend_mask);
    assign merged  = pend_split ? {live, merge_q} : {32'h0, live};
    assign shifted = merged >> {pend_o, 3'b000};
    assign sh32    = shifted[31:0];

    always_comb begin
        case (pend_f3)
            3'b000:  ext = {{24{sh32[7]}}, sh32[7:0]};
            3'b001:  ext = {{16{sh32[15]}}, sh32[15:0]};
            3'b100:  ext = {24'h0, sh32[7:0]};
            3'b101:  ext = {16'h0, sh32[15:0]};
            default: ext = sh32;
        endcase
    end

    assign rsp_vld = pend_vld & ~rst;
    assign rsp_rd  = rsp_vld ? ext : 32'h0;

    assign unused_bits = ^{req_a[31:AW], shifted[63:32]};

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-array SRAM model plus a byte-level reference memory;
// directed cases followed by randomized loads and stores.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0, req_ld = 1'b0, req_st = 1'b0;
    logic [2:0]  req_f3 = 3'b000;
    logic [31:0] req_a = 32'h0, req_wd = 32'h0;
    logic        req_rdy;
    logic [15:0] dat_a;
    logic [3:0]  dat_we, dat_re;
    logic [31:0] dat_wd, dat_rd, rsp_rd;
    logic        rsp_vld, err;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] rd_q;
    bit          mem_init = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_lsu #(.AW(16)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_ld(req_ld), .req_st(req_st),
        .req_f3(req_f3), .req_a(req_a), .req_wd(req_wd), .req_rdy(req_rdy),
        .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re),
        .dat_rd(dat_rd), .rsp_vld(rsp_vld), .rsp_rd(rsp_rd), .err(err)
    );

    always #5 clk = ~clk;

    // Read-first SRAM; lanes that were not enabled return junk.
    always @(posedge clk) begin
        logic [15:0] idx;
        if (!mem_init) begin
            for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
            mem_init = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            idx = {dat_a[15:2], 2'(i)};
            rd_q[8*i +: 8] <= dat_re[i] ? mem[idx] : 8'($urandom);
            if (dat_we[i]) mem[idx] = dat_wd[8*i +: 8];
        end
    end
    assign dat_rd = rd_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Which lanes each of the two words touches, derived byte by byte.
    task automatic masks(input logic [15:0] a, input int s, output logic [3:0] m1, output logic [3:0] m2);
        logic [15:0] b;
        m1 = 4'b0000;
        m2 = 4'b0000;
        for (int i = 0; i < s; i++) begin
            b = 16'(a + 16'(i));
            if (b[15:2] == a[15:2]) m1[b[1:0]] = 1'b1;
            else                    m2[b[1:0]] = 1'b1;
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [15:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int s;
        s = size_of(f3);
        v = 32'h0;
        for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[16'(a + 16'(i))];
        if (!f3[2] && s == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && s == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic do_load(input logic [15:0] a, input logic [2:0] f3, output logic [31:0] got);
        logic [3:0]  m1, m2;
        logic [15:0] w;
        logic [31:0] exp;
        exp = ref_load(a, f3);
        masks(a, size_of(f3), m1, m2);
        w = {a[15:2], 2'b00};
        @(negedge clk);
        req_vld = 1'b1; req_ld = 1'b1; req_st = 1'b0;
        req_f3 = f3; req_a = {16'h0, a}; req_wd = $urandom;
        #1;
        chk("ld_rdy", 32'(req_rdy), 32'd1);
        chk("ld_a0", 32'(dat_a), 32'(w));
        chk("ld_re0", 32'(dat_re), 32'(m1));
        chk("ld_we0", 32'(dat_we), 32'd0);
        @(negedge clk);
        req_vld = 1'b0;
        #1;
        if (m2 != 4'b0000) begin
            chk("ld_a1", 32'(dat_a), 32'(16'(w + 16'd4)));
            chk("ld_re1", 32'(dat_re), 32'(m2));
            chk("ld_rdy_split", 32'(req_rdy), 32'd0);
            chk("ld_vld_early", 32'(rsp_vld), 32'd0);
            @(negedge clk);
            #1;
        end
        chk("ld_vld", 32'(rsp_vld), 32'd1);
        chk("ld_rd", rsp_rd, exp);
        got = rsp_rd;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [2:0] f3, input logic [31:0] wd);
        logic [3:0]  m1, m2;
        logic [15:0] w, b;
        int s;
        s = size_of(f3);
        masks(a, s, m1, m2);
        w = {a[15:2], 2'b00};
        for (int i = 0; i < s; i++) ref_mem[16'(a + 16'(i))] = wd[8*i +: 8];
        @(negedge clk);
        req_vld = 1'b1; req_ld = 1'b0; req_st = 1'b1;
        req_f3 = f3; req_a = {16'h0, a}; req_wd = wd;
        #1;
        chk("st_a0", 32'(dat_a), 32'(w));
        chk("st_we0", 32'(dat_we), 32'(m1));
        chk("st_re0", 32'(dat_re), 32'd0);
        for (int i = 0; i < s; i++) begin
            b = 16'(a + 16'(i));
            if (b[15:2] == a[15:2]) chk("st_lane0", 32'(dat_wd[8*b[1:0] +: 8]), 32'(wd[8*i +: 8]));
        end
        @(negedge clk);
        req_vld = 1'b0; req_st = 1'b0;
        #1;
        if (m2 != 4'b0000) begin
            chk("st_a1", 32'(dat_a), 32'(16'(w + 16'd4)));
            chk("st_we1", 32'(dat_we), 32'(m2));
            chk("st_rdy_split", 32'(req_rdy), 32'd0);
            for (int i = 0; i < s; i++) begin
                b = 16'(a + 16'(i));
                if (b[15:2] != a[15:2]) chk("st_lane1", 32'(dat_wd[8*b[1:0] +: 8]), 32'(wd[8*i +: 8]));
            end
            @(negedge clk);
            #1;
        end
        chk("st_no_rsp", 32'(rsp_vld), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [15:0] ra;
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        for (int k = 0; k < 65536; k++) ref_mem[k] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_re", 32'(dat_re), 32'd0);
        chk("rst_we", 32'(dat_we), 32'd0);
        chk("rst_a", 32'(dat_a), 32'd0);
        chk("rst_wd", dat_wd, 32'd0);
        chk("rst_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rd", rsp_rd, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rdy_after_rst", 32'(req_rdy), 32'd1);

        // Aligned LW
        do_store(16'h0028, 3'b010, 32'h11223344);
        do_load(16'h0028, 3'b010, got);
        chk("lw_aligned", got, 32'h11223344);

        // LB / LBU with sign bit
        do_store(16'h002B, 3'b000, 32'h00000080);
        do_load(16'h002B, 3'b000, got);
        chk("lb_sign", got, 32'hFFFFFF80);
        do_load(16'h002B, 3'b100, got);
        chk("lbu_zero", got, 32'h00000080);

        // SH upper half
        do_store(16'h0028, 3'b010, 32'h11223344);
        do_store(16'h002A, 3'b001, 32'h0000BEEF);
        do_load(16'h0028, 3'b010, got);
        chk("sh_upper", got, 32'hBEEF3344);

        // Split LW
        do_store(16'h002C, 3'b010, 32'hDDCCBBAA);
        do_store(16'h0030, 3'b010, 32'h44332211);
        do_load(16'h002E, 3'b010, got);
        chk("lw_split", got, 32'h2211DDCC);

        // Split SW across the top of the address space
        do_store(16'hFFFF, 3'b010, 32'hAABBCCDD);
        do_load(16'hFFFF, 3'b010, got);
        chk("sw_wrap_rd", got, 32'hAABBCCDD);
        do_load(16'h0000, 3'b100, got);
        chk("sw_wrap_b0", got, 32'h000000CC);

        // Back-to-back aligned loads: response overlaps the next accept
        @(negedge clk);
        req_vld = 1'b1; req_ld = 1'b1; req_st = 1'b0; req_f3 = 3'b010; req_a = 32'h28;
        @(negedge clk);
        req_a = 32'h2C;
        #1;
        chk("b2b_rdy", 32'(req_rdy), 32'd1);
        chk("b2b_re", 32'(dat_re), 32'hF);
        chk("b2b_vld0", 32'(rsp_vld), 32'd1);
        chk("b2b_rd0", rsp_rd, 32'hBEEF3344);
        @(negedge clk);
        req_vld = 1'b0;
        #1;
        chk("b2b_vld1", 32'(rsp_vld), 32'd1);
        chk("b2b_rd1", rsp_rd, 32'hDDCCBBAA);

        // Illegal funct3 on a load and on a store; ld+st together
        @(negedge clk);
        req_vld = 1'b1; req_ld = 1'b1; req_st = 1'b0; req_f3 = 3'b011; req_a = 32'h28;
        #1;
        chk("ill_ld_err", 32'(err), 32'd1);
        chk("ill_ld_re", 32'(dat_re), 32'd0);
        @(negedge clk);
        req_ld = 1'b0; req_st = 1'b1; req_f3 = 3'b100;
        #1;
        chk("ill_ld_novld", 32'(rsp_vld), 32'd0);
        chk("ill_st_err", 32'(err), 32'd1);
        chk("ill_st_we", 32'(dat_we), 32'd0);
        @(negedge clk);
        req_ld = 1'b1; req_st = 1'b1; req_f3 = 3'b010;
        #1;
        chk("both_err", 32'(err), 32'd0);
        chk("both_re", 32'(dat_re), 32'd0);
        chk("both_we", 32'(dat_we), 32'd0);
        @(negedge clk);
        req_vld = 1'b0; req_ld = 1'b0; req_st = 1'b0;
        #1;
        chk("err_pulse", 32'(err), 32'd0);
        chk("both_novld", 32'(rsp_vld), 32'd0);

        // Reset during SPLIT of a split LW
        @(negedge clk);
        req_vld = 1'b1; req_ld = 1'b1; req_f3 = 3'b010; req_a = 32'h2E;
        @(negedge clk);
        req_vld = 1'b0; req_ld = 1'b0; rst = 1'b1;
        #1;
        chk("rsplit_re", 32'(dat_re), 32'd0);
        @(negedge clk);
        #1;
        chk("rsplit_re_n1", 32'(dat_re), 32'd0);
        chk("rsplit_vld_n1", 32'(rsp_vld), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rsplit_rdy", 32'(req_rdy), 32'd1);
        chk("rsplit_vld", 32'(rsp_vld), 32'd0);
        do_load(16'h002E, 3'b010, got);
        chk("rsplit_recover", got, 32'h2211DDCC);

        // Randomized traffic in a low window and a window straddling the wrap
        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom_range(0, 47));
            if ($urandom_range(0, 1) == 1) ra = 16'(ra + 16'hFFE8);
            if ($urandom_range(0, 1) == 1) do_store(ra, 3'($urandom_range(0, 2)), $urandom);
            else                           do_load(ra, ld_f3[$urandom_range(0, 4)], got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
